fx_chain_scheduler: RTL and testbench

//  Sequences the effect chain for each audio sample. Accepts one sample from the codec path and

---
 rtl/fx_pkg.sv | 20 ++
 rtl/fx_sram_mux.sv | 52 +++++
 rtl/fx_chain_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_fx_chain_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx_pkg.sv
// Shared definitions for the effect-chain scheduler: FSM encoding and slot slicing helpers.
package fx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SCAN      = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_OUT       = 2'd3
    } fx_state_e;

    localparam int FX_N_FX_DEF      = 4;
    localparam int FX_DATA_WIDTH_DEF = 16;
    localparam int FX_ADDR_WIDTH_DEF = 12;

    // Low bit of slot k inside a flattened per-slot bus of w-bit fields.
    function automatic int slot_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/fx_sram_mux.sv
// Combinational smart_ram request mux and finish demux, selected by the one-hot turn grant.
module fx_sram_mux
    import fx_pkg::*;
#(
    parameter int N_FX       = FX_N_FX_DEF,
    parameter int DATA_WIDTH = FX_DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = FX_ADDR_WIDTH_DEF
) (
    input  logic [N_FX-1:0]            grant_i,
    input  logic [N_FX-1:0]            fx_rd_i,
    input  logic [N_FX-1:0]            fx_wr_i,
    input  logic [N_FX*ADDR_WIDTH-1:0] fx_offset_i,
    input  logic [N_FX*DATA_WIDTH-1:0] fx_wdata_i,
    output logic [N_FX-1:0]            fx_rfin_o,
    output logic [N_FX-1:0]            fx_wfin_o,
    output logic                       sram_rd_o,
    output logic                       sram_wr_o,
    output logic [ADDR_WIDTH-1:0]      sram_offset_o,
    output logic [DATA_WIDTH-1:0]      sram_wdata_o,
    input  logic                       sram_rfin_i,
    input  logic                       sram_wfin_i
);

    logic [N_FX-1:0]       rd_m;
    logic [N_FX-1:0]       wr_m;
    logic [ADDR_WIDTH-1:0] off_m [N_FX];
    logic [DATA_WIDTH-1:0] wd_m  [N_FX];

    // AND-OR selection: the grant is one-hot or zero, so no priority is needed.
    for (genvar gi = 0; gi < N_FX; gi++) begin : g_slot
        assign rd_m[gi]      = grant_i[gi] & fx_rd_i[gi];
        assign wr_m[gi]      = grant_i[gi] & fx_wr_i[gi];
        assign off_m[gi]     = {ADDR_WIDTH{grant_i[gi]}}
                             & fx_offset_i[slot_lo(gi, ADDR_WIDTH) +: ADDR_WIDTH];
        assign wd_m[gi]      = {DATA_WIDTH{grant_i[gi]}}
                             & fx_wdata_i[slot_lo(gi, DATA_WIDTH) +: DATA_WIDTH];
        assign fx_rfin_o[gi] = grant_i[gi] & sram_rfin_i;
        assign fx_wfin_o[gi] = grant_i[gi] & sram_wfin_i;
    end

    always_comb begin
        sram_rd_o     = |rd_m;
        sram_wr_o     = |wr_m;
        sram_offset_o = '0;
        sram_wdata_o  = '0;
        for (int i = 0; i < N_FX; i++) begin
            sram_offset_o = sram_offset_o | off_m[i];
            sram_wdata_o  = sram_wdata_o  | wd_m[i];
        end
    end

endmodule

// File: rtl/fx_chain_scheduler.sv
// Per-sample effect-chain sequencer: walks enabled slots in index order via my_turn/done,
// shares one smart_ram port with the granted slot, and produces the periodic save strobe.
module fx_chain_scheduler
    import fx_pkg::*;
#(
    parameter int N_FX       = FX_N_FX_DEF,
    parameter int DATA_WIDTH = FX_DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = FX_ADDR_WIDTH_DEF,
    parameter int SAVE_DIV   = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_valid_i,
    input  logic [DATA_WIDTH-1:0]      sample_in_i,
    output logic [DATA_WIDTH-1:0]      sample_out_o,
    output logic                       sample_out_valid_o,
    output logic                       busy_o,
    output logic                       overrun_o,
    input  logic [N_FX-1:0]            fx_enable_i,
    output logic [N_FX-1:0]            fx_my_turn_o,
    input  logic [N_FX-1:0]            fx_done_i,
    input  logic [N_FX*DATA_WIDTH-1:0] fx_data_out_i,
    output logic [DATA_WIDTH-1:0]      fx_data_in_o,
    output logic                       fx_should_save_o,
    output logic [N_FX-1:0]            fx_fault_o,
    input  logic [N_FX-1:0]            fx_sram_rd_i,
    input  logic [N_FX-1:0]            fx_sram_wr_i,
    input  logic [N_FX*ADDR_WIDTH-1:0] fx_sram_offset_i,
    input  logic [N_FX*DATA_WIDTH-1:0] fx_sram_wdata_i,
    output logic [N_FX-1:0]            fx_sram_rfin_o,
    output logic [N_FX-1:0]            fx_sram_wfin_o,
    output logic                       sram_rd_o,
    output logic                       sram_wr_o,
    output logic [ADDR_WIDTH-1:0]      sram_offset_o,
    output logic [DATA_WIDTH-1:0]      sram_data_out_o,
    input  logic                       sram_read_finish_i,
    input  logic                       sram_write_finish_i
);

    localparam int KW = (N_FX > 1) ? $clog2(N_FX) : 1;
    localparam int IW = $clog2(N_FX + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int SW = (SAVE_DIV > 1) ? $clog2(SAVE_DIV) : 1;

    fx_state_e             state_q,       state_d;
    logic [IW-1:0]         idx_q,         idx_d;
    logic [KW-1:0]         cur_q,         cur_d;
    logic [TW-1:0]         tmo_q,         tmo_d;
    logic [SW-1:0]         save_cnt_q,    save_cnt_d;
    logic                  should_save_q, should_save_d;
    logic [DATA_WIDTH-1:0] chain_q,       chain_d;
    logic [N_FX-1:0]       en_snap_q,     en_snap_d;
    logic [N_FX-1:0]       my_turn_q,     my_turn_d;
    logic [N_FX-1:0]       fault_q,       fault_d;
    logic [DATA_WIDTH-1:0] out_q,         out_d;
    logic                  out_valid_q,   out_valid_d;
    logic                  overrun_q,     overrun_d;

    logic [DATA_WIDTH-1:0] slot_data [N_FX];
    logic                  found;
    logic [KW-1:0]         k_sel;

    for (genvar gi = 0; gi < N_FX; gi++) begin : g_slot_data
        assign slot_data[gi] = fx_data_out_i[slot_lo(gi, DATA_WIDTH) +: DATA_WIDTH];
    end

    // Lowest enabled slot at or above idx; scanning downward lets the lowest match win.
    always_comb begin
        found = 1'b0;
        k_sel = '0;
        for (int i = N_FX - 1; i >= 0; i--) begin
            if (en_snap_q[i] && (i >= int'(idx_q))) begin
                found = 1'b1;
                k_sel = KW'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cur_d         = cur_q;
        tmo_d         = tmo_q;
        save_cnt_d    = save_cnt_q;
        should_save_d = should_save_q;
        chain_d       = chain_q;
        en_snap_d     = en_snap_q;
        my_turn_d     = my_turn_q;
        fault_d       = fault_q;
        out_d         = out_q;
        out_valid_d   = 1'b0;
        overrun_d     = overrun_q;

        if (sample_valid_i && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (sample_valid_i) begin
                    chain_d       = sample_in_i;
                    en_snap_d     = fx_enable_i;
                    idx_d         = '0;
                    should_save_d = (save_cnt_q == '0);
                    save_cnt_d    = (save_cnt_q == SW'(SAVE_DIV - 1)) ? '0
                                                                      : save_cnt_q + SW'(1);
                    state_d       = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (found) begin
                    my_turn_d        = '0;
                    my_turn_d[k_sel] = 1'b1;
                    cur_d            = k_sel;
                    tmo_d            = '0;
                    state_d          = ST_WAIT_DONE;
                end else begin
                    // Result registered here so it is visible during the OUT cycle.
                    out_d       = chain_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
            end
            ST_WAIT_DONE: begin
                if (fx_done_i[cur_q]) begin
                    chain_d   = slot_data[cur_q];
                    my_turn_d = '0;
                    idx_d     = IW'(cur_q) + IW'(1);
                    state_d   = ST_SCAN;
                end else if (tmo_q == TW'(TIMEOUT)) begin
                    my_turn_d      = '0;
                    fault_d[cur_q] = 1'b1;
                    idx_d          = IW'(cur_q) + IW'(1);
                    state_d        = ST_SCAN;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_OUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            cur_q         <= '0;
            tmo_q         <= '0;
            save_cnt_q    <= '0;
            should_save_q <= 1'b0;
            chain_q       <= '0;
            en_snap_q     <= '0;
            my_turn_q     <= '0;
            fault_q       <= '0;
            out_q         <= '0;
            out_valid_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cur_q         <= cur_d;
            tmo_q         <= tmo_d;
            save_cnt_q    <= save_cnt_d;
            should_save_q <= should_save_d;
            chain_q       <= chain_d;
            en_snap_q     <= en_snap_d;
            my_turn_q     <= my_turn_d;
            fault_q       <= fault_d;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign sample_out_o       = out_q;
    assign sample_out_valid_o = out_valid_q;
    assign busy_o             = (state_q != ST_IDLE);
    assign overrun_o          = overrun_q;
    assign fx_my_turn_o       = my_turn_q;
    assign fx_data_in_o       = chain_q;
    assign fx_should_save_o   = should_save_q;
    assign fx_fault_o         = fault_q;

    // Grant is the registered turn, so a timed-out slot loses the port and its late finishes.
    fx_sram_mux #(
        .N_FX       (N_FX),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sram_mux (
        .grant_i       (my_turn_q),
        .fx_rd_i       (fx_sram_rd_i),
        .fx_wr_i       (fx_sram_wr_i),
        .fx_offset_i   (fx_sram_offset_i),
        .fx_wdata_i    (fx_sram_wdata_i),
        .fx_rfin_o     (fx_sram_rfin_o),
        .fx_wfin_o     (fx_sram_wfin_o),
        .sram_rd_o     (sram_rd_o),
        .sram_wr_o     (sram_wr_o),
        .sram_offset_o (sram_offset_o),
        .sram_wdata_o  (sram_data_out_o),
        .sram_rfin_i   (sram_read_finish_i),
        .sram_wfin_i   (sram_write_finish_i)
    );

endmodule

// File: tb/tb_fx_chain_scheduler.sv
// Directed bench for fx_chain_scheduler: vector table of chain results plus corner sequences.
module tb_fx_chain_scheduler;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic [DW-1:0] sample_out;
    logic          sample_out_valid;
    logic          busy;
    logic          overrun;
    logic [N-1:0]  fx_enable = '0;
    logic [N-1:0]  fx_my_turn;
    logic [N-1:0]  fx_done;
    logic [N*DW-1:0] fx_data_out;
    logic [DW-1:0] fx_data_in;
    logic          fx_should_save;
    logic [N-1:0]  fx_fault;
    logic [N-1:0]  fx_sram_rd;
    logic [N-1:0]  fx_sram_wr;
    logic [N*AW-1:0] fx_sram_offset;
    logic [N*DW-1:0] fx_sram_wdata;
    logic [N-1:0]  fx_sram_rfin;
    logic [N-1:0]  fx_sram_wfin;
    logic          sram_rd;
    logic          sram_wr;
    logic [AW-1:0] sram_offset;
    logic [DW-1:0] sram_data_out;
    logic          sram_read_finish = 1'b0;
    logic          sram_write_finish = 1'b0;

    logic [N-1:0]  hang = '0;
    logic [N-1:0]  rd_mode = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int nsamp = 0;
    int turn_log [$];
    logic [N-1:0] prev_turn = '0;

    always #5 clk = ~clk;

    fx_chain_scheduler #(
        .N_FX(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SAVE_DIV(4), .TIMEOUT(15)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .sample_valid_i      (sample_valid),
        .sample_in_i         (sample_in),
        .sample_out_o        (sample_out),
        .sample_out_valid_o  (sample_out_valid),
        .busy_o              (busy),
        .overrun_o           (overrun),
        .fx_enable_i         (fx_enable),
        .fx_my_turn_o        (fx_my_turn),
        .fx_done_i           (fx_done),
        .fx_data_out_i       (fx_data_out),
        .fx_data_in_o        (fx_data_in),
        .fx_should_save_o    (fx_should_save),
        .fx_fault_o          (fx_fault),
        .fx_sram_rd_i        (fx_sram_rd),
        .fx_sram_wr_i        (fx_sram_wr),
        .fx_sram_offset_i    (fx_sram_offset),
        .fx_sram_wdata_i     (fx_sram_wdata),
        .fx_sram_rfin_o      (fx_sram_rfin),
        .fx_sram_wfin_o      (fx_sram_wfin),
        .sram_rd_o           (sram_rd),
        .sram_wr_o           (sram_wr),
        .sram_offset_o       (sram_offset),
        .sram_data_out_o     (sram_data_out),
        .sram_read_finish_i  (sram_read_finish),
        .sram_write_finish_i (sram_write_finish)
    );

    // Effect models: done 3 cycles after the turn rises, result = input + 0x10.
    for (genvar gi = 0; gi < N; gi++) begin : g_fx
        logic [2:0] cnt = '0;
        always @(posedge clk) begin
            if (!fx_my_turn[gi]) cnt <= '0;
            else if (cnt != 3'd7) cnt <= cnt + 3'd1;
        end
        assign fx_done[gi]                = fx_my_turn[gi] && (cnt == 3'd3) && !hang[gi];
        assign fx_data_out[gi*DW +: DW]   = fx_data_in + 16'h0010;
        assign fx_sram_rd[gi]             = fx_my_turn[gi] & rd_mode[gi];
        assign fx_sram_wr[gi]             = 1'b0;
        assign fx_sram_offset[gi*AW +: AW] = AW'(12'h111 * (gi + 1));
        assign fx_sram_wdata[gi*DW +: DW] = DW'(16'hD000 + gi);
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (fx_my_turn[i] && !prev_turn[i]) turn_log.push_back(i);
        end
        prev_turn = fx_my_turn;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (sample_out_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) chk({name, "_out_valid_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_turn(input string name, input logic [N-1:0] want);
        bit seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (fx_my_turn == want) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) chk({name, "_turn_timeout"}, 32'(fx_my_turn), 32'(want));
    endtask

    task automatic check_turns(input string name, input logic [N-1:0] exp_mask);
        logic [N-1:0] mask = '0;
        int last = -1;
        bit order_ok = 1'b1;
        foreach (turn_log[j]) begin
            if (turn_log[j] <= last) order_ok = 1'b0;
            last = turn_log[j];
            mask[turn_log[j]] = 1'b1;
        end
        chk({name, "_turn_mask"}, 32'(mask), 32'(exp_mask));
        chk({name, "_turn_order"}, 32'(order_ok), 32'd1);
    endtask

    // Full sample transaction; enables are flipped after acceptance to prove the snapshot.
    task automatic run_sample(input string name, input logic [N-1:0] en,
                              input logic [DW-1:0] din, input logic [DW-1:0] exp);
        turn_log.delete();
        fx_enable    = en;
        sample_in    = din;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        fx_enable    = ~en;
        chk({name, "_save"}, 32'(fx_should_save), 32'((nsamp % 4) == 0));
        nsamp++;
        wait_out(name);
        chk({name, "_out"}, 32'(sample_out), 32'(exp));
        check_turns(name, en);
        tick();
        chk({name, "_idle"}, {30'd0, busy, sample_out_valid}, 32'd0);
        $display("sample %s en=%b in=0x%04h out=0x%04h", name, en, din, sample_out);
    endtask

    typedef struct {
        logic [N-1:0]  en;
        logic [DW-1:0] din;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{4'b0101, 16'h0100, 16'h0120};
        vecs[1] = '{4'b1111, 16'hFFF0, 16'h0030};
        vecs[2] = '{4'b1000, 16'h7FF8, 16'h8008};
        vecs[3] = '{4'b0010, 16'h0001, 16'h0011};
        vecs[4] = '{4'b1110, 16'h8000, 16'h8030};
        vecs[5] = '{4'b0000, 16'hABCD, 16'hABCD};
        vecs[6] = '{4'b0011, 16'h00F0, 16'h0110};
        vecs[7] = '{4'b1001, 16'h1000, 16'h1020};

        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outs", {sample_out, 8'd0, fx_my_turn, fx_fault, 3'd0, sample_out_valid,
                         overrun, fx_should_save, sram_rd, sram_wr}, 32'd0);
        rst_n = 1'b1;
        tick();

        // No slots enabled: valid two cycles after the strobe, no turn issued.
        turn_log.delete();
        fx_enable    = '0;
        sample_in    = 16'h1234;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("lat_t1_valid", 32'(sample_out_valid), 32'd0);
        chk("lat_t1_busy", 32'(busy), 32'd1);
        chk("lat_save", 32'(fx_should_save), 32'd1);
        nsamp++;
        tick();
        chk("lat_t2_valid", 32'(sample_out_valid), 32'd1);
        chk("lat_t2_out", 32'(sample_out), 32'h1234);
        tick();
        chk("lat_t3_valid", 32'(sample_out_valid), 32'd0);
        chk("lat_t3_busy", 32'(busy), 32'd0);
        chk("lat_no_turn", 32'(turn_log.size()), 32'd0);
        $display("sample lat en=0000 in=0x1234 out=0x%04h", sample_out);

        for (int v = 0; v < 8; v++) begin
            run_sample($sformatf("vec%0d", v), vecs[v].en, vecs[v].din, vecs[v].exp);
        end

        // Slot1 hangs: it times out, slot0's value passes, late finishes are dropped.
        hang = 4'b0010;
        fx_enable    = 4'b0011;
        sample_in    = 16'h0200;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        nsamp++;
        wait_turn("tmo", 4'b0010);
        sram_write_finish = 1'b1;
        #1;
        chk("tmo_wfin_routed", 32'(fx_sram_wfin), 32'b0010);
        sram_write_finish = 1'b0;
        wait_out("tmo");
        chk("tmo_out", 32'(sample_out), 32'h0210);
        chk("tmo_fault", 32'(fx_fault), 32'b0010);
        tick();
        sram_write_finish = 1'b1;
        #1;
        chk("tmo_late_wfin", 32'(fx_sram_wfin), 32'd0);
        sram_write_finish = 1'b0;
        hang = '0;
        $display("sample tmo en=0011 in=0x0200 out=0x%04h fault=%b", sample_out, fx_fault);

        // Strobe during WAIT_DONE is dropped and flagged.
        fx_enable    = 4'b0001;
        sample_in    = 16'h0300;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        nsamp++;
        wait_turn("ovr", 4'b0001);
        chk("ovr_before", 32'(overrun), 32'd0);
        sample_in    = 16'h5555;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("ovr_set", 32'(overrun), 32'd1);
        wait_out("ovr");
        chk("ovr_out", 32'(sample_out), 32'h0310);
        repeat (3) tick();
        chk("ovr_dropped", {30'd0, busy, overrun}, 32'd1);
        $display("sample ovr en=0001 in=0x0300 out=0x%04h overrun=%b", sample_out, overrun);

        // Async reset while slot3 holds an SRAM read.
        rd_mode      = 4'b1000;
        fx_enable    = 4'b1000;
        sample_in    = 16'h0400;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        wait_turn("arst", 4'b1000);
        chk("arst_sram_rd", 32'(sram_rd), 32'd1);
        chk("arst_sram_off", 32'(sram_offset), 32'h444);
        chk("arst_sram_wd", 32'(sram_data_out), 32'hD003);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_turn_rd", {28'd0, fx_my_turn} | {31'd0, sram_rd}, 32'd0);
        chk("arst_outs", {sample_out, fx_data_in}, 32'd0);
        chk("arst_flags", {24'd0, fx_fault, busy, overrun, fx_should_save, sample_out_valid},
            32'd0);
        tick();
        rd_mode = '0;
        rst_n   = 1'b1;
        nsamp   = 0;
        tick();
        run_sample("post_rst", 4'b0101, 16'h0100, 16'h0120);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
